// File: rtl/pos_cell_stream_reader_if.sv
// Particle stream link from the cell position reader
// to the force/motion pipeline.
interface pos_cell_stream_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_pid;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data, out_pid, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_pid, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/pos_cell_stream_reader.sv
// Cell position read engine: fetches the particle count,
// then streams words 1..N through a credit-gated FWFT buffer.
module pos_cell_stream_reader #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  pos_cell_stream_reader_if.master stream
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_REQ,
    S_CNT_WAIT,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [ADDR_WIDTH-1:0] pid;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  state_t                state_q;
  logic                  wait_q;
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] next_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rden_q;
  logic                  issue_q;
  logic                  s1_q;
  logic                  s2_q;
  logic [ADDR_WIDTH-1:0] s1_pid_q;
  logic [ADDR_WIDTH-1:0] s2_pid_q;
  logic [CW-1:0]         inflight_q;
  logic [CW-1:0]         fifo_cnt_q;
  logic [PW-1:0]         wr_q;
  logic [PW-1:0]         rd_q;
  ent_t                  fifo_q [FIFO_DEPTH];

  ent_t                  head;
  ent_t                  wr_ent;
  logic [ADDR_WIDTH-1:0] cnt_w;
  logic [CW-1:0]         used;
  logic                  push;
  logic                  pop;
  logic                  can_issue;
  logic                  issue_go;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cnt_w     = mem_q[ADDR_WIDTH-1:0];
  assign head      = fifo_q[rd_q];
  assign push      = s2_q;
  assign pop       = stream.out_valid && stream.out_ready;
  // Slots already promised: buffered words plus reads in flight.
  assign used      = fifo_cnt_q + inflight_q - CW'(pop);
  assign can_issue = used < DEPTH_C;
  assign issue_go  = (state_q == S_STREAM && can_issue) ||
                     (state_q == S_CNT_WAIT && wait_q && cnt_w != '0);
  assign wr_ent    = '{last: (s2_pid_q == n_q),
                       pid:  s2_pid_q,
                       data: mem_q};

  assign mem_addr         = addr_q;
  assign mem_rden         = rden_q;
  assign mem_wren         = 1'b0;
  assign busy             = state_q != S_IDLE;
  assign done             = (state_q == S_FIN) || (pop && head.last);
  assign stream.out_valid = fifo_cnt_q != '0;
  assign stream.out_data  = head.data;
  assign stream.out_pid   = head.pid;
  assign stream.out_last  = head.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= 1'b0;
      n_q        <= '0;
      next_q     <= '0;
      addr_q     <= '0;
      rden_q     <= 1'b0;
      issue_q    <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s1_pid_q   <= '0;
      s2_pid_q   <= '0;
      inflight_q <= '0;
    end else begin
      rden_q     <= issue_go;
      issue_q    <= issue_go;
      s1_q       <= issue_q;
      s2_q       <= s1_q;
      s1_pid_q   <= addr_q;
      s2_pid_q   <= s1_pid_q;
      inflight_q <= inflight_q + CW'(issue_go) - CW'(push);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CNT_REQ;
            rden_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        S_CNT_REQ: begin
          state_q <= S_CNT_WAIT;
          wait_q  <= 1'b0;
        end
        S_CNT_WAIT: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            n_q <= cnt_w;
            if (cnt_w == '0) begin
              state_q <= S_FIN;
            end else begin
              addr_q  <= ADDR_WIDTH'(1);
              next_q  <= ADDR_WIDTH'(2);
              state_q <= (cnt_w == ADDR_WIDTH'(1)) ? S_DRAIN : S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (can_issue) begin
            addr_q <= next_q;
            if (next_q == n_q) state_q <= S_DRAIN;
            else               next_q  <= next_q + 1'b1;
          end
        end
        // Accepting word N finishes the run; nothing else is pending then.
        S_DRAIN: begin
          if (pop && head.last) state_q <= S_IDLE;
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= wr_ent;
        wr_q         <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_cnt_q == DEPTH_C));
endmodule
